ign_scheduler: RTL and testbench

IGN_SCHEDULER -- requirements
Module: ign_scheduler

---
 rtl/ign_scheduler.sv | 151 +++++++++++++++
 tb/tb_ign_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ign_scheduler.sv
// Ignition scheduler: scans the cylinder timing table on each tooth and
// hands spark delays to a small pool of shared countdown channels.
module ign_scheduler #(
    parameter int NCYL     = 4,
    parameter int NCHAN    = 2,
    parameter int MARGIN   = 20,
    parameter int LAT_COMP = 6
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            trigger,
    input  logic [15:0]     eng_phase,
    input  logic [15:0]     next_tooth_width,
    input  logic [31:0]     tooth_period,
    input  logic            cfg_we,
    input  logic [1:0]      cfg_addr,
    input  logic [15:0]     cfg_data,
    output logic [NCYL-1:0] fire,
    output logic [NCYL-1:0] armed,
    output logic            busy,
    output logic [7:0]      miss_cnt,
    output logic            overrun_err
);
    typedef enum logic {S_IDLE, S_SCAN} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_idx;
    logic [15:0] r_phase;
    logic [15:0] r_width;
    logic [31:0] r_period;
    logic [15:0] r_table [NCYL];
    logic [31:0] r_cnt [NCHAN];
    logic [1:0]  r_cyl [NCHAN];
    logic [NCHAN-1:0] r_act;
    logic [NCYL-1:0]  r_fire;
    logic [7:0]  r_miss;
    logic        r_ovr;

    logic [15:0] w_timing;
    logic [17:0] w_limit;
    logic        w_pass;
    logic [15:0] w_delta;
    logic [47:0] w_prod;
    logic [39:0] w_shift;
    logic [31:0] w_sat;
    logic [31:0] w_delay;
    logic [NCYL-1:0] w_armed;
    logic [NCYL-1:0] w_fire_cyl;
    logic        w_free_ok;
    logic [1:0]  w_free_idx;
    logic        w_eval;
    logic        w_load;
    logic        w_drop;

    // Window check and delay arithmetic for the cylinder under evaluation
    always_comb begin
        w_timing = r_table[r_idx];
        w_limit  = {2'b00, r_phase} + {2'b00, r_width} + 18'(MARGIN);
        w_pass   = (w_timing > r_phase) && ({2'b00, w_timing} <= w_limit);
        w_delta  = w_timing - r_phase;
        w_prod   = {16'd0, r_period} * {32'd0, w_delta};
        w_shift  = 40'(w_prod >> 8);
        w_sat    = (|w_shift[39:32]) ? 32'hFFFF_FFFF : w_shift[31:0];
        w_delay  = (w_sat < 32'(LAT_COMP)) ? 32'd0 : w_sat - 32'(LAT_COMP);
    end

    always_comb begin
        w_armed    = '0;
        w_fire_cyl = '0;
        w_free_ok  = 1'b0;
        w_free_idx = 2'd0;
        for (int ch = 0; ch < NCHAN; ch++) begin
            if (r_act[ch]) begin
                w_armed[r_cyl[ch]] = 1'b1;
                if (r_cnt[ch] == 32'd0)
                    w_fire_cyl[r_cyl[ch]] = 1'b1;
            end
        end
        // Walk downward so the lowest free channel wins
        for (int ch = NCHAN - 1; ch >= 0; ch--) begin
            if (!r_act[ch]) begin
                w_free_ok  = 1'b1;
                w_free_idx = 2'(ch);
            end
        end
    end

    assign w_eval = (r_state == S_SCAN) && w_pass && !w_armed[r_idx];
    assign w_load = w_eval && w_free_ok;
    assign w_drop = w_eval && !w_free_ok;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (trigger) w_state_nxt = S_SCAN;
            S_SCAN: if (r_idx == 2'(NCYL - 1)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_idx    <= 2'd0;
            r_phase  <= 16'd0;
            r_width  <= 16'd0;
            r_period <= 32'd0;
            r_act    <= '0;
            r_fire   <= '0;
            r_miss   <= 8'd0;
            r_ovr    <= 1'b0;
            for (int c = 0; c < NCYL; c++) r_table[c] <= 16'd0;
            for (int ch = 0; ch < NCHAN; ch++) begin
                r_cnt[ch] <= 32'd0;
                r_cyl[ch] <= 2'd0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && trigger) begin
                r_idx    <= 2'd0;
                r_phase  <= eng_phase;
                r_width  <= next_tooth_width;
                r_period <= tooth_period;
            end
            if (r_state == S_SCAN) begin
                r_idx <= r_idx + 2'd1;
                if (trigger) r_ovr <= 1'b1;
            end
            if (cfg_we) r_table[cfg_addr] <= cfg_data;
            for (int ch = 0; ch < NCHAN; ch++) begin
                if (w_load && w_free_idx == 2'(ch)) begin
                    r_act[ch] <= 1'b1;
                    r_cnt[ch] <= w_delay;
                    r_cyl[ch] <= r_idx;
                end else if (r_act[ch]) begin
                    if (r_cnt[ch] == 32'd0) r_act[ch] <= 1'b0;
                    else r_cnt[ch] <= r_cnt[ch] - 32'd1;
                end
            end
            r_fire <= w_fire_cyl;
            if (w_drop && r_miss != 8'hFF) r_miss <= r_miss + 8'd1;
        end
    end

    assign fire        = r_fire;
    assign armed       = w_armed;
    assign busy        = (r_state == S_SCAN);
    assign miss_cnt    = r_miss;
    assign overrun_err = r_ovr;
endmodule

// File: tb/tb_ign_scheduler.sv
// Directed bench for ign_scheduler: single event, contention, window
// edges, small delta, reset mid-countdown, overrun and armed skip.
module tb_ign_scheduler;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        trigger = 1'b0;
    logic [15:0] eng_phase = 16'd0;
    logic [15:0] next_tooth_width = 16'd0;
    logic [31:0] tooth_period = 32'd0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = 2'd0;
    logic [15:0] cfg_data = 16'd0;
    logic [3:0]  fire;
    logic [3:0]  armed;
    logic        busy;
    logic [7:0]  miss_cnt;
    logic        overrun_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    int fire_first [4];
    int fire_cnt [4];

    ign_scheduler dut (
        .clk(clk), .reset_n(reset_n), .trigger(trigger),
        .eng_phase(eng_phase), .next_tooth_width(next_tooth_width),
        .tooth_period(tooth_period), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .fire(fire), .armed(armed), .busy(busy),
        .miss_cnt(miss_cnt), .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        trigger = 1'b0;
        cfg_we  = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic cfg(input logic [1:0] a, input logic [15:0] d);
        cfg_addr = a;
        cfg_data = d;
        cfg_we   = 1'b1;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic set_tooth(input logic [15:0] ph, input logic [15:0] w,
                             input logic [31:0] p);
        eng_phase        = ph;
        next_tooth_width = w;
        tooth_period     = p;
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        t0 = cyc;
    endtask

    task automatic clear_watch();
        for (int c = 0; c < 4; c++) begin
            fire_first[c] = -1;
            fire_cnt[c]   = 0;
        end
    endtask

    task automatic watch(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            for (int c = 0; c < 4; c++) begin
                if (fire[c]) begin
                    if (fire_first[c] < 0) fire_first[c] = cyc - t0;
                    fire_cnt[c]++;
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({fire, armed, busy, miss_cnt, overrun_err} !== 18'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0",
                     {fire, armed, busy, miss_cnt, overrun_err});
        end
    endtask

    task automatic test_single();
        do_reset();
        cfg(2'd0, 16'd100);
        set_tooth(16'd90, 16'd20, 32'd256);
        clear_watch();
        pulse_trigger();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy: got %b want 1", busy);
        end
        watch(1);
        checks++;
        if (armed !== 4'b0001) begin
            errors++;
            $display("FAIL single_armed_t1: got %b want 0001", armed);
        end
        watch(4);
        checks++;
        if (armed !== 4'b0001 || fire_cnt[0] != 0) begin
            errors++;
            $display("FAIL single_armed_t5: armed %b fires %0d want 0001/0",
                     armed, fire_cnt[0]);
        end
        watch(1);
        checks++;
        if (fire !== 4'b0001 || armed !== 4'b0000) begin
            errors++;
            $display("FAIL single_t6: fire %b armed %b want 0001/0000",
                     fire, armed);
        end
        watch(5);
        checks++;
        if (fire_first[0] != 6 || fire_cnt[0] != 1) begin
            errors++;
            $display("FAIL single_fire: at %0d n %0d want 6/1",
                     fire_first[0], fire_cnt[0]);
        end
    endtask

    task automatic test_contention();
        do_reset();
        cfg(2'd0, 16'd100);
        cfg(2'd1, 16'd100);
        cfg(2'd2, 16'd100);
        set_tooth(16'd90, 16'd20, 32'd256);
        clear_watch();
        pulse_trigger();
        watch(12);
        checks++;
        if (fire_first[0] != 6 || fire_first[1] != 7) begin
            errors++;
            $display("FAIL contention_fire: c0 %0d c1 %0d want 6/7",
                     fire_first[0], fire_first[1]);
        end
        checks++;
        if (fire_cnt[2] != 0 || miss_cnt !== 8'd1) begin
            errors++;
            $display("FAIL contention_drop: c2 %0d miss %0d want 0/1",
                     fire_cnt[2], miss_cnt);
        end
    endtask

    task automatic test_window();
        do_reset();
        cfg(2'd0, 16'd90);
        cfg(2'd1, 16'd130);
        cfg(2'd2, 16'd131);
        set_tooth(16'd90, 16'd20, 32'd256);
        clear_watch();
        pulse_trigger();
        watch(4);
        checks++;
        if (armed !== 4'b0010 || miss_cnt !== 8'd0) begin
            errors++;
            $display("FAIL window_arm: armed %b miss %0d want 0010/0",
                     armed, miss_cnt);
        end
        watch(40);
        checks++;
        if (fire_first[1] != 37 || fire_cnt[0] != 0 || fire_cnt[2] != 0) begin
            errors++;
            $display("FAIL window_fire: c1 at %0d c0 n %0d c2 n %0d want 37/0/0",
                     fire_first[1], fire_cnt[0], fire_cnt[2]);
        end
    endtask

    task automatic test_small_delta();
        do_reset();
        cfg(2'd0, 16'd95);
        set_tooth(16'd90, 16'd20, 32'd256);
        clear_watch();
        pulse_trigger();
        watch(6);
        checks++;
        if (fire_first[0] != 2 || fire_cnt[0] != 1) begin
            errors++;
            $display("FAIL small_delta: at %0d n %0d want 2/1",
                     fire_first[0], fire_cnt[0]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cfg(2'd0, 16'd200);
        set_tooth(16'd0, 16'd200, 32'd256);
        clear_watch();
        pulse_trigger();
        watch(9);
        checks++;
        if (armed !== 4'b0001) begin
            errors++;
            $display("FAIL reset_mid_armed: got %b want 0001", armed);
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checks++;
        if ({fire, armed, busy, miss_cnt, overrun_err} !== 18'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %h want 0",
                     {fire, armed, busy, miss_cnt, overrun_err});
        end
        clear_watch();
        watch(250);
        checks++;
        if (fire_cnt[0] != 0) begin
            errors++;
            $display("FAIL reset_mid_nofire: n %0d want 0", fire_cnt[0]);
        end
        pulse_trigger();
        watch(6);
        checks++;
        if (armed !== 4'b0000 || fire_cnt[0] != 0) begin
            errors++;
            $display("FAIL reset_mid_table: armed %b n %0d want 0000/0",
                     armed, fire_cnt[0]);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        cfg(2'd0, 16'd100);
        set_tooth(16'd90, 16'd20, 32'd256);
        clear_watch();
        pulse_trigger();
        tick();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        checks++;
        if (overrun_err !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL overrun_flag: ovr %b busy %b want 1/1",
                     overrun_err, busy);
        end
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL overrun_busy: got %b want 0", busy);
        end
        watch(10);
        checks++;
        if (fire_first[0] != 6 || fire_cnt[0] != 1 || busy !== 1'b0
            || overrun_err !== 1'b1) begin
            errors++;
            $display("FAIL overrun_event: at %0d n %0d busy %b ovr %b want 6/1/0/1",
                     fire_first[0], fire_cnt[0], busy, overrun_err);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cfg(2'd0, 16'd200);
        set_tooth(16'd0, 16'd200, 32'd256);
        clear_watch();
        pulse_trigger();
        watch(5);
        cfg(2'd0, 16'd100);
        pulse_trigger();
        watch(4);
        checks++;
        if (armed !== 4'b0001 || miss_cnt !== 8'd0) begin
            errors++;
            $display("FAIL b2b_skip: armed %b miss %0d want 0001/0",
                     armed, miss_cnt);
        end
        watch(200);
        checks++;
        if (fire_first[0] != 189 || fire_cnt[0] != 1) begin
            errors++;
            $display("FAIL b2b_fire: at %0d n %0d want 189/1",
                     fire_first[0], fire_cnt[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_window();
        test_small_delta();
        test_reset_mid();
        test_overrun();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
